// File: rtl/cpu_ctrl_pkg.sv
// Shared opcodes, ALU select codes, FSM states and the control-word bundle
// for the multi-cycle CPU control unit.
package cpu_ctrl_pkg;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_INC  = 4'h1;
    localparam logic [3:0] OP_DEC  = 4'h2;
    localparam logic [3:0] OP_LD   = 4'h3;
    localparam logic [3:0] OP_ST   = 4'h4;
    localparam logic [3:0] OP_JMP  = 4'h5;
    localparam logic [3:0] OP_JZ   = 4'h6;
    localparam logic [3:0] OP_JC   = 4'h7;
    localparam logic [3:0] OP_PUSH = 4'h8;
    localparam logic [3:0] OP_POP  = 4'h9;
    localparam logic [3:0] OP_HLT  = 4'hF;

    localparam logic [2:0] FS_ADD  = 3'b000;
    localparam logic [2:0] FS_SUB  = 3'b001;
    localparam logic [2:0] FS_PASS = 3'b010;

    typedef enum logic [2:0] {S_RST, FETCH, DECODE, EXEC, HALT, PAUSE} state_t;

    typedef struct packed {
        logic       lmar, lir, lbuff, lpc, lsp, lreg, lmdr, lalu;
        logic       tpc, tmdr, t1, tbuff, tsp, treg, tlabel;
        logic       wr, rd;
        logic [2:0] fsel;
        logic       halted, illegal, instr_done;
    } ctrl_t;

    // A memory microstep is one that holds rd or wr across the wait count.
    function automatic logic is_mem(input ctrl_t c);
        return c.rd | c.wr;
    endfunction

endpackage

// File: rtl/cpu_ctrl_decode.sv
// Combinational microcode: (state, step, opcode, latched flags, wait status)
// to the full datapath control word.
module cpu_ctrl_decode
    import cpu_ctrl_pkg::*;
#(
    parameter int STEP_W = 3
) (
    input  state_t            state,
    input  logic [STEP_W-1:0] step,
    input  logic [3:0]        opcode,
    input  logic              flag_z,
    input  logic              flag_c,
    input  logic              wait_done,
    output ctrl_t             cw
);

    logic last;

    always_comb begin
        cw   = '0;
        last = 1'b0;
        case (state)
            FETCH: begin
                case (int'(step))
                    0: begin cw.tpc = 1'b1; cw.fsel = FS_PASS; cw.lalu = 1'b1; cw.lmar = 1'b1; end
                    1: cw.rd = 1'b1;
                    2: begin cw.tmdr = 1'b1; cw.fsel = FS_PASS; cw.lalu = 1'b1; cw.lir = 1'b1; end
                    3: begin cw.tpc = 1'b1; cw.lbuff = 1'b1; end
                    4: begin cw.t1 = 1'b1; cw.tbuff = 1'b1; cw.fsel = FS_ADD; cw.lalu = 1'b1; cw.lpc = 1'b1; end
                    default: ;
                endcase
            end
            EXEC: begin
                case (opcode)
                    OP_NOP: last = 1'b1;
                    OP_INC: begin
                        case (int'(step))
                            0: begin cw.treg = 1'b1; cw.lbuff = 1'b1; end
                            1: begin
                                cw.t1 = 1'b1; cw.tbuff = 1'b1; cw.fsel = FS_ADD;
                                cw.lalu = 1'b1; cw.lreg = 1'b1; last = 1'b1;
                            end
                            default: ;
                        endcase
                    end
                    OP_DEC: begin
                        case (int'(step))
                            0: begin cw.t1 = 1'b1; cw.lbuff = 1'b1; end
                            1: begin
                                cw.treg = 1'b1; cw.tbuff = 1'b1; cw.fsel = FS_SUB;
                                cw.lalu = 1'b1; cw.lreg = 1'b1; last = 1'b1;
                            end
                            default: ;
                        endcase
                    end
                    OP_LD: begin
                        case (int'(step))
                            0: begin cw.tlabel = 1'b1; cw.fsel = FS_PASS; cw.lalu = 1'b1; cw.lmar = 1'b1; end
                            1: cw.rd = 1'b1;
                            2: begin
                                cw.tmdr = 1'b1; cw.fsel = FS_PASS; cw.lalu = 1'b1;
                                cw.lreg = 1'b1; last = 1'b1;
                            end
                            default: ;
                        endcase
                    end
                    OP_ST: begin
                        case (int'(step))
                            0: begin cw.tlabel = 1'b1; cw.fsel = FS_PASS; cw.lalu = 1'b1; cw.lmar = 1'b1; end
                            1: begin cw.treg = 1'b1; cw.fsel = FS_PASS; cw.lalu = 1'b1; cw.lmdr = 1'b1; end
                            2: begin cw.wr = 1'b1; last = 1'b1; end
                            default: ;
                        endcase
                    end
                    OP_JMP, OP_JZ, OP_JC: begin
                        last = 1'b1;
                        // Conditional jumps test the flags latched by the last INC/DEC.
                        if (opcode == OP_JMP || (opcode == OP_JZ && flag_z) ||
                            (opcode == OP_JC && flag_c)) begin
                            cw.tlabel = 1'b1; cw.fsel = FS_PASS; cw.lalu = 1'b1; cw.lpc = 1'b1;
                        end
                    end
                    OP_PUSH: begin
                        case (int'(step))
                            0: begin cw.t1 = 1'b1; cw.lbuff = 1'b1; end
                            1: begin
                                cw.tsp = 1'b1; cw.tbuff = 1'b1; cw.fsel = FS_SUB;
                                cw.lalu = 1'b1; cw.lsp = 1'b1; cw.lmar = 1'b1;
                            end
                            2: begin cw.treg = 1'b1; cw.fsel = FS_PASS; cw.lalu = 1'b1; cw.lmdr = 1'b1; end
                            3: begin cw.wr = 1'b1; last = 1'b1; end
                            default: ;
                        endcase
                    end
                    OP_POP: begin
                        case (int'(step))
                            0: begin cw.tsp = 1'b1; cw.fsel = FS_PASS; cw.lalu = 1'b1; cw.lmar = 1'b1; end
                            1: cw.rd = 1'b1;
                            2: begin cw.tmdr = 1'b1; cw.fsel = FS_PASS; cw.lalu = 1'b1; cw.lreg = 1'b1; end
                            3: begin cw.tsp = 1'b1; cw.lbuff = 1'b1; end
                            4: begin
                                cw.t1 = 1'b1; cw.tbuff = 1'b1; cw.fsel = FS_ADD;
                                cw.lalu = 1'b1; cw.lsp = 1'b1; last = 1'b1;
                            end
                            default: ;
                        endcase
                    end
                    OP_HLT: ;
                    default: begin cw.illegal = 1'b1; last = 1'b1; end
                endcase
            end
            HALT: cw.halted = 1'b1;
            default: ;
        endcase
        // A final memory step signals completion only on its last wait cycle.
        cw.instr_done = last && (!is_mem(cw) || wait_done);
    end

endmodule

// File: rtl/cpu_control_unit.sv
// Hardwired multi-cycle CPU control FSM: fetch, decode, per-opcode execute, halt.
// Define SINGLE_STEP_EN to add step_req and a PAUSE state after every instruction.
module cpu_control_unit
    import cpu_ctrl_pkg::*;
#(
    parameter int MEM_WAIT = 1,
    parameter int STEP_W   = 3
) (
    input  logic        clk,
    input  logic        rst,
`ifdef SINGLE_STEP_EN
    input  logic        step_req,
`endif
    input  logic [15:0] IR1,
    input  logic        C,
    input  logic        V,
    input  logic        S,
    input  logic        Z,
    output logic        Lmar,
    output logic        Lir,
    output logic        Lbuff,
    output logic        Lpc,
    output logic        Lsp,
    output logic        Lreg,
    output logic        Lmdr,
    output logic        Lalu,
    output logic        Tpc,
    output logic        Tmdr,
    output logic        T1,
    output logic        Tbuff,
    output logic        Tsp,
    output logic        Treg,
    output logic        Tlabel,
    output logic        wr,
    output logic        rd,
    output logic [2:0]  fsel,
    output logic        halted,
    output logic        illegal,
    output logic        instr_done
);

    localparam logic [2:0] WAIT_INIT = 3'(MEM_WAIT - 1);

    state_t            state;
    logic [STEP_W-1:0] step;
    logic [2:0]        wait_cnt;
    logic [3:0]        flags;     // {C,V,S,Z}
    logic [3:0]        opcode;
    logic              hold;
    ctrl_t             cw;

    assign opcode = IR1[15:12];

    cpu_ctrl_decode #(.STEP_W(STEP_W)) u_decode (
        .state     (state),
        .step      (step),
        .opcode    (opcode),
        .flag_z    (flags[0]),
        .flag_c    (flags[3]),
        .wait_done (wait_cnt == 3'd0),
        .cw        (cw)
    );

    // Stay on a memory step until the wait counter reaches zero.
    assign hold = is_mem(cw) && (wait_cnt != 3'd0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_RST;
            step     <= '0;
            wait_cnt <= WAIT_INIT;
            flags    <= '0;
        end else if (hold) begin
            wait_cnt <= wait_cnt - 3'd1;
        end else begin
            wait_cnt <= WAIT_INIT;
            case (state)
                S_RST: begin
                    state <= FETCH;
                    step  <= '0;
                end
                FETCH: begin
                    if (step == STEP_W'(4)) begin
                        state <= DECODE;
                        step  <= '0;
                    end else begin
                        step <= step + STEP_W'(1);
                    end
                end
                DECODE: begin
                    state <= EXEC;
                    step  <= '0;
                end
                EXEC: begin
                    if ((opcode == OP_INC || opcode == OP_DEC) && step == STEP_W'(1))
                        flags <= {C, V, S, Z};
                    if (opcode == OP_HLT) begin
                        state <= HALT;
                    end else if (cw.instr_done) begin
`ifdef SINGLE_STEP_EN
                        state <= PAUSE;
`else
                        state <= FETCH;
`endif
                        step  <= '0;
                    end else begin
                        step <= step + STEP_W'(1);
                    end
                end
                HALT: ;
`ifdef SINGLE_STEP_EN
                PAUSE: if (step_req) state <= FETCH;
`endif
                default: state <= S_RST;
            endcase
        end
    end

    assign Lmar       = cw.lmar;
    assign Lir        = cw.lir;
    assign Lbuff      = cw.lbuff;
    assign Lpc        = cw.lpc;
    assign Lsp        = cw.lsp;
    assign Lreg       = cw.lreg;
    assign Lmdr       = cw.lmdr;
    assign Lalu       = cw.lalu;
    assign Tpc        = cw.tpc;
    assign Tmdr       = cw.tmdr;
    assign T1         = cw.t1;
    assign Tbuff      = cw.tbuff;
    assign Tsp        = cw.tsp;
    assign Treg       = cw.treg;
    assign Tlabel     = cw.tlabel;
    assign wr         = cw.wr;
    assign rd         = cw.rd;
    assign fsel       = cw.fsel;
    assign halted     = cw.halted;
    assign illegal    = cw.illegal;
    assign instr_done = cw.instr_done;

    // Label/register fields and V/S are consumed by the datapath, not here.
    logic unused;
    assign unused = ^{IR1[11:0], flags[2:1]};

endmodule

// File: tb/tb_cpu_control_unit.sv
// Scoreboard bench for cpu_control_unit: per-cycle expected control words are
// queued when an instruction is issued and compared against the strobes.
module tb_cpu_control_unit;

    localparam int MW = 3;

    localparam logic [22:0] K_LMAR   = 23'h1 << 22;
    localparam logic [22:0] K_LIR    = 23'h1 << 21;
    localparam logic [22:0] K_LBUFF  = 23'h1 << 20;
    localparam logic [22:0] K_LPC    = 23'h1 << 19;
    localparam logic [22:0] K_LSP    = 23'h1 << 18;
    localparam logic [22:0] K_LREG   = 23'h1 << 17;
    localparam logic [22:0] K_LMDR   = 23'h1 << 16;
    localparam logic [22:0] K_LALU   = 23'h1 << 15;
    localparam logic [22:0] K_TPC    = 23'h1 << 14;
    localparam logic [22:0] K_TMDR   = 23'h1 << 13;
    localparam logic [22:0] K_T1     = 23'h1 << 12;
    localparam logic [22:0] K_TBUFF  = 23'h1 << 11;
    localparam logic [22:0] K_TSP    = 23'h1 << 10;
    localparam logic [22:0] K_TREG   = 23'h1 << 9;
    localparam logic [22:0] K_TLABEL = 23'h1 << 8;
    localparam logic [22:0] K_WR     = 23'h1 << 7;
    localparam logic [22:0] K_RD     = 23'h1 << 6;
    localparam logic [22:0] K_SUB    = 23'h1 << 3;
    localparam logic [22:0] K_PASS   = 23'h2 << 3;
    localparam logic [22:0] K_HALTED = 23'h1 << 2;
    localparam logic [22:0] K_ILL    = 23'h1 << 1;
    localparam logic [22:0] K_DONE   = 23'h1;
    localparam logic [22:0] K_F0     = K_TPC | K_PASS | K_LALU | K_LMAR;

    logic clk = 1'b0;
    logic rst;
    logic [15:0] IR1;
    logic C, V, S, Z;
    logic Lmar, Lir, Lbuff, Lpc, Lsp, Lreg, Lmdr, Lalu;
    logic Tpc, Tmdr, T1, Tbuff, Tsp, Treg, Tlabel;
    logic wr, rd, halted, illegal, instr_done;
    logic [2:0] fsel;
`ifdef SINGLE_STEP_EN
    logic step_req = 1'b1;
`endif

    always #5 clk = ~clk;

    cpu_control_unit #(.MEM_WAIT(MW), .STEP_W(3)) dut (
        .clk(clk), .rst(rst),
`ifdef SINGLE_STEP_EN
        .step_req(step_req),
`endif
        .IR1(IR1), .C(C), .V(V), .S(S), .Z(Z),
        .Lmar(Lmar), .Lir(Lir), .Lbuff(Lbuff), .Lpc(Lpc), .Lsp(Lsp), .Lreg(Lreg),
        .Lmdr(Lmdr), .Lalu(Lalu), .Tpc(Tpc), .Tmdr(Tmdr), .T1(T1), .Tbuff(Tbuff),
        .Tsp(Tsp), .Treg(Treg), .Tlabel(Tlabel), .wr(wr), .rd(rd), .fsel(fsel),
        .halted(halted), .illegal(illegal), .instr_done(instr_done)
    );

    logic [22:0] obs;
    assign obs = {Lmar, Lir, Lbuff, Lpc, Lsp, Lreg, Lmdr, Lalu, Tpc, Tmdr, T1, Tbuff,
                  Tsp, Treg, Tlabel, wr, rd, fsel, halted, illegal, instr_done};

    typedef struct {
        logic [15:0] ir;
        logic [3:0]  f;    // {C,V,S,Z}
        logic [22:0] exp;
    } ent_t;

    ent_t q[$];
    ent_t e;
    int   n_chk = 0;
    int   n_fail = 0;
    logic mz, mc;          // reference copy of the latched Z/C flags

    function automatic void add(input logic [15:0] ir, input logic [3:0] f, input logic [22:0] v);
        q.push_back('{ir, f, v});
    endfunction

    function automatic void push_instr(input logic [15:0] ir, input logic [3:0] f);
        logic [3:0] op;
        op = ir[15:12];
        add(ir, f, K_F0);
        for (int i = 0; i < MW; i++) add(ir, f, K_RD);
        add(ir, f, K_TMDR | K_PASS | K_LALU | K_LIR);
        add(ir, f, K_TPC | K_LBUFF);
        add(ir, f, K_T1 | K_TBUFF | K_LALU | K_LPC);
        add(ir, f, '0);
        case (op)
            4'h0: add(ir, f, K_DONE);
            4'h1: begin
                add(ir, f, K_TREG | K_LBUFF);
                add(ir, f, K_T1 | K_TBUFF | K_LALU | K_LREG | K_DONE);
                mz = f[0]; mc = f[3];
            end
            4'h2: begin
                add(ir, f, K_T1 | K_LBUFF);
                add(ir, f, K_TREG | K_TBUFF | K_SUB | K_LALU | K_LREG | K_DONE);
                mz = f[0]; mc = f[3];
            end
            4'h3: begin
                add(ir, f, K_TLABEL | K_PASS | K_LALU | K_LMAR);
                for (int i = 0; i < MW; i++) add(ir, f, K_RD);
                add(ir, f, K_TMDR | K_PASS | K_LALU | K_LREG | K_DONE);
            end
            4'h4: begin
                add(ir, f, K_TLABEL | K_PASS | K_LALU | K_LMAR);
                add(ir, f, K_TREG | K_PASS | K_LALU | K_LMDR);
                for (int i = 0; i < MW; i++) add(ir, f, K_WR | ((i == MW - 1) ? K_DONE : 23'h0));
            end
            4'h5: add(ir, f, K_TLABEL | K_PASS | K_LALU | K_LPC | K_DONE);
            4'h6: add(ir, f, (mz ? (K_TLABEL | K_PASS | K_LALU | K_LPC) : 23'h0) | K_DONE);
            4'h7: add(ir, f, (mc ? (K_TLABEL | K_PASS | K_LALU | K_LPC) : 23'h0) | K_DONE);
            4'h8: begin
                add(ir, f, K_T1 | K_LBUFF);
                add(ir, f, K_TSP | K_TBUFF | K_SUB | K_LALU | K_LSP | K_LMAR);
                add(ir, f, K_TREG | K_PASS | K_LALU | K_LMDR);
                for (int i = 0; i < MW; i++) add(ir, f, K_WR | ((i == MW - 1) ? K_DONE : 23'h0));
            end
            4'h9: begin
                add(ir, f, K_TSP | K_PASS | K_LALU | K_LMAR);
                for (int i = 0; i < MW; i++) add(ir, f, K_RD);
                add(ir, f, K_TMDR | K_PASS | K_LALU | K_LREG);
                add(ir, f, K_TSP | K_LBUFF);
                add(ir, f, K_T1 | K_TBUFF | K_LALU | K_LSP | K_DONE);
            end
            4'hF: add(ir, f, '0);
            default: add(ir, f, K_ILL | K_DONE);
        endcase
`ifdef SINGLE_STEP_EN
        if (op != 4'hF) add(ir, f, '0);
`endif
    endfunction

    task automatic test_reset();
        rst = 1'b0; IR1 = '0; {C, V, S, Z} = 4'h0; mz = 1'b0; mc = 1'b0;
        q.delete();
        repeat (3) @(negedge clk);
        n_chk++;
        if (obs !== 23'h0) begin
            n_fail++; $display("FAIL reset_outputs got=%h exp=%h", obs, 23'h0);
        end
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        n_chk++;
        if (obs !== 23'h0) begin
            n_fail++; $display("FAIL srst_cycle got=%h exp=%h", obs, 23'h0);
        end
        @(negedge clk);
    endtask

    task automatic test_nop();
        int cyc = 0;
        int done_cyc = -1;
        push_instr(16'h0000, 4'h0);
        while (q.size() > 0) begin
            e = q.pop_front();
            IR1 = e.ir; {C, V, S, Z} = e.f; #1;
            cyc++;
            if (instr_done) done_cyc = cyc;
            n_chk++;
            if (obs !== e.exp) begin
                n_fail++; $display("FAIL nop cyc=%0d got=%h exp=%h", cyc, obs, e.exp);
            end
            @(negedge clk);
        end
        n_chk++;
        if (done_cyc != 6 + MW) begin
            n_fail++; $display("FAIL nop_latency got=%0d exp=%0d", done_cyc, 6 + MW);
        end
        #1;
        n_chk++;
        if (obs !== K_F0) begin
            n_fail++; $display("FAIL next_f0 got=%h exp=%h", obs, K_F0);
        end
    endtask

    task automatic test_flags_branch();
        int cyc = 0;
        push_instr(16'h1020, 4'b0001);   // INC, Z=1 latched
        push_instr(16'h6005, 4'b0000);   // JZ taken on latched Z
        push_instr(16'h7005, 4'b1000);   // JC not taken: live C ignored
        push_instr(16'h2040, 4'b1000);   // DEC, C=1 Z=0 latched
        push_instr(16'h6005, 4'b0001);   // JZ not taken
        push_instr(16'h0000, 4'b0000);   // NOP keeps flags
        push_instr(16'h7005, 4'b0000);   // JC taken
        while (q.size() > 0) begin
            e = q.pop_front();
            IR1 = e.ir; {C, V, S, Z} = e.f; #1;
            cyc++;
            n_chk++;
            if (obs !== e.exp) begin
                n_fail++; $display("FAIL flags_branch cyc=%0d ir=%h got=%h exp=%h", cyc, e.ir, obs, e.exp);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_mem_wait();
        int cyc = 0;
        int run = 0;
        push_instr(16'h3040, 4'h0);      // LD r2
        push_instr(16'h4050, 4'h0);      // ST
        while (q.size() > 0) begin
            e = q.pop_front();
            IR1 = e.ir; {C, V, S, Z} = e.f; #1;
            cyc++;
            n_chk++;
            if (obs !== e.exp) begin
                n_fail++; $display("FAIL mem cyc=%0d got=%h exp=%h", cyc, obs, e.exp);
            end
            n_chk++;
            if (rd && (wr || Lmdr)) begin
                n_fail++; $display("FAIL rd_exclusive cyc=%0d rd=%b wr=%b lmdr=%b exp=rd_alone", cyc, rd, wr, Lmdr);
            end
            if (rd) run++;
            else if (run != 0) begin
                n_chk++;
                if (run != MW) begin
                    n_fail++; $display("FAIL rd_len got=%0d exp=%0d", run, MW);
                end
                run = 0;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_stack();
        int cyc = 0;
        push_instr(16'h8060, 4'h0);      // PUSH r3
        push_instr(16'h9060, 4'h0);      // POP r3
        push_instr(16'h5123, 4'h0);      // JMP
        while (q.size() > 0) begin
            e = q.pop_front();
            IR1 = e.ir; {C, V, S, Z} = e.f; #1;
            cyc++;
            n_chk++;
            if (obs !== e.exp) begin
                n_fail++; $display("FAIL stack cyc=%0d ir=%h got=%h exp=%h", cyc, e.ir, obs, e.exp);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_illegal();
        int cyc = 0;
        int pulses = 0;
        push_instr(16'hB000, 4'h0);
        push_instr(16'hA000, 4'h0);
        push_instr(16'hE000, 4'h0);
        while (q.size() > 0) begin
            e = q.pop_front();
            IR1 = e.ir; {C, V, S, Z} = e.f; #1;
            cyc++;
            if (illegal) pulses++;
            n_chk++;
            if (obs !== e.exp) begin
                n_fail++; $display("FAIL illegal cyc=%0d got=%h exp=%h", cyc, obs, e.exp);
            end
            @(negedge clk);
        end
        n_chk++;
        if (pulses != 3) begin
            n_fail++; $display("FAIL illegal_pulses got=%0d exp=3", pulses);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] ops [12];
        int cyc = 0;
        ops = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'hC, 4'h6};
        for (int i = 0; i < 16; i++)
            push_instr({ops[$urandom_range(11)], 12'($urandom)}, 4'($urandom));
        while (q.size() > 0) begin
            e = q.pop_front();
            IR1 = e.ir; {C, V, S, Z} = e.f; #1;
            cyc++;
            n_chk++;
            if (obs !== e.exp) begin
                n_fail++; $display("FAIL b2b cyc=%0d ir=%h got=%h exp=%h", cyc, e.ir, obs, e.exp);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_halt();
        int cyc = 0;
        push_instr(16'hF000, 4'h0);
        for (int i = 0; i < 50; i++) add(16'hF000, 4'($urandom), K_HALTED);
        while (q.size() > 0) begin
            e = q.pop_front();
            IR1 = e.ir; {C, V, S, Z} = e.f; #1;
            cyc++;
            n_chk++;
            if (obs !== e.exp) begin
                n_fail++; $display("FAIL halt cyc=%0d got=%h exp=%h", cyc, obs, e.exp);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid();
        int cyc = 0;
        rst = 1'b0; mz = 1'b0; mc = 1'b0; q.delete();
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk); @(negedge clk);
        push_instr(16'h1000, 4'b1001);   // INC latches C=1,Z=1 before the reset
        push_instr(16'h9060, 4'h0);
        // Stop at POP E2 and drop reset there.
        while (q.size() > 0) begin
            e = q.pop_front();
            IR1 = e.ir; {C, V, S, Z} = e.f; #1;
            cyc++;
            n_chk++;
            if (obs !== e.exp) begin
                n_fail++; $display("FAIL pop_pre cyc=%0d got=%h exp=%h", cyc, obs, e.exp);
            end
            if (e.exp == (K_TMDR | K_PASS | K_LALU | K_LREG)) break;
            @(negedge clk);
        end
        rst = 1'b0; #1;
        n_chk++;
        if (obs !== 23'h0) begin
            n_fail++; $display("FAIL async_drop got=%h exp=%h", obs, 23'h0);
        end
        q.delete(); mz = 1'b0; mc = 1'b0;
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        n_chk++;
        if (obs !== 23'h0) begin
            n_fail++; $display("FAIL srst_after_mid got=%h exp=%h", obs, 23'h0);
        end
        @(negedge clk);
        push_instr(16'h6005, 4'b1001);   // flags cleared by reset: JZ not taken
        push_instr(16'h7005, 4'b1001);
        cyc = 0;
        while (q.size() > 0) begin
            e = q.pop_front();
            IR1 = e.ir; {C, V, S, Z} = e.f; #1;
            cyc++;
            n_chk++;
            if (obs !== e.exp) begin
                n_fail++; $display("FAIL post_reset cyc=%0d got=%h exp=%h", cyc, obs, e.exp);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_nop();
        test_flags_branch();
        test_mem_wait();
        test_stack();
        test_illegal();
        test_back_to_back();
        test_halt();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
